// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding,
// load-use stall, multi-cycle EX hold, taken-branch flush, debug single-step and perf counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_BITS = 5,
  parameter int FW_BUS_WIDTH  = 2,
  parameter int FLUSH_DEPTH   = 3,
  parameter int MULTI_LAT     = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_ADDR_BITS-1:0] id_rs_addr,
  input  logic [REG_ADDR_BITS-1:0] id_rt_addr,
  input  logic                     id_uses_rt,
  input  logic [REG_ADDR_BITS-1:0] ex_rs_addr,
  input  logic [REG_ADDR_BITS-1:0] ex_rt_addr,
  input  logic                     ex_mem_read,
  input  logic [REG_ADDR_BITS-1:0] ex_rd_addr,
  input  logic                     ex_multi_start,
  input  logic                     mem_reg_write,
  input  logic [REG_ADDR_BITS-1:0] mem_rd_addr,
  input  logic                     wb_reg_write,
  input  logic [REG_ADDR_BITS-1:0] wb_rd_addr,
  input  logic                     branch_taken,
  input  logic                     dbg_step_mode,
  input  logic                     dbg_step,
  output logic [FW_BUS_WIDTH-1:0]  fw_rs_sel,
  output logic [FW_BUS_WIDTH-1:0]  fw_rt_sel,
  output logic                     pc_enable,
  output logic                     ifid_enable,
  output logic                     ex_hold,
  output logic                     idex_bubble,
  output logic [FLUSH_DEPTH-1:0]   flush_mask,
  output logic [CNT_BITS-1:0]      stall_cycles,
  output logic [CNT_BITS-1:0]      step_count
);

  localparam int MC_BITS = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
  localparam logic [MC_BITS-1:0]      MC_LOAD = MC_BITS'(MULTI_LAT - 2);
  localparam logic [FW_BUS_WIDTH-1:0] FW_REG  = FW_BUS_WIDTH'(0);
  localparam logic [FW_BUS_WIDTH-1:0] FW_MEM  = FW_BUS_WIDTH'(1);
  localparam logic [FW_BUS_WIDTH-1:0] FW_WB   = FW_BUS_WIDTH'(2);

  typedef enum logic {RUN = 1'b0, MULTI = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [MC_BITS-1:0] mcnt, mcnt_nxt;
  logic               frozen, luse, multi_hold;

  // MEM beats WB; register 0 is hard-wired and never forwarded
  function automatic logic [FW_BUS_WIDTH-1:0] fw_pick(
    input logic [REG_ADDR_BITS-1:0] src,
    input logic                     m_we,
    input logic [REG_ADDR_BITS-1:0] m_rd,
    input logic                     w_we,
    input logic [REG_ADDR_BITS-1:0] w_rd
  );
    logic [FW_BUS_WIDTH-1:0] sel;
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      sel = FW_MEM;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      sel = FW_WB;
    end else begin
      sel = FW_REG;
    end
    return sel;
  endfunction

  always_comb begin
    frozen     = dbg_step_mode & ~dbg_step;
    luse       = ex_mem_read & (ex_rd_addr != '0) &
                 ((ex_rd_addr == id_rs_addr) | (id_uses_rt & (ex_rd_addr == id_rt_addr)));
    multi_hold = (state == MULTI) | ex_multi_start;
  end

  // Pipeline controls; priority is reset, debug freeze, branch, multi-cycle hold, load-use
  always_comb begin
    fw_rs_sel   = fw_pick(ex_rs_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
    fw_rt_sel   = fw_pick(ex_rt_addr, mem_reg_write, mem_rd_addr, wb_reg_write, wb_rd_addr);
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    ex_hold     = 1'b0;
    idex_bubble = 1'b0;
    flush_mask  = '0;
    if (reset) begin
      fw_rs_sel   = FW_REG;
      fw_rt_sel   = FW_REG;
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_bubble = 1'b1;
      flush_mask  = '1;
    end else if (frozen) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      ex_hold     = 1'b1;
    end else if (branch_taken) begin
      flush_mask  = '1;
    end else if (multi_hold) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      ex_hold     = 1'b1;
    end else if (luse) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      pc_enable   = 1'b1;
    end
  end

  // A frozen cycle keeps the sequencer untouched; a branch aborts any multi-cycle op
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    if (frozen) begin
      state_nxt = state;
    end else if (branch_taken) begin
      state_nxt = RUN;
      mcnt_nxt  = '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_multi_start) begin
            state_nxt = MULTI;
            mcnt_nxt  = MC_LOAD;
          end else begin
            mcnt_nxt  = '0;
          end
        end
        MULTI: begin
          if (mcnt == '0) begin
            state_nxt = RUN;
          end else begin
            mcnt_nxt  = mcnt - MC_BITS'(1);
          end
        end
        default: begin
          state_nxt = RUN;
          mcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      mcnt  <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // Free-running wrap-around counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      step_count   <= '0;
    end else begin
      if (!pc_enable) begin
        stall_cycles <= stall_cycles + CNT_BITS'(1);
      end
      if (dbg_step_mode && dbg_step) begin
        step_count <= step_count + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scenario bench for hazard_ctrl_unit; a second instance with 4-bit counters checks wrap-around.
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs, ex_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_multi_start;
    logic       mem_reg_write;
    logic [4:0] mem_rd;
    logic       wb_reg_write;
    logic [4:0] wb_rd;
    logic       branch_taken, dbg_step_mode, dbg_step;
  } in_t;

  typedef struct packed {
    logic [1:0] rs, rt;
    logic       pc, ifid, hold, bub;
    logic [2:0] flush;
  } out_t;

  typedef struct packed {
    out_t        o;
    logic [39:0] cnt;
    logic        valid;
  } sb_t;

  localparam out_t FREE  = '{rs: 2'd0, rt: 2'd0, pc: 1'b1, ifid: 1'b1, hold: 1'b0, bub: 1'b0, flush: 3'b000};
  localparam out_t RST   = '{rs: 2'd0, rt: 2'd0, pc: 1'b0, ifid: 1'b0, hold: 1'b0, bub: 1'b1, flush: 3'b111};
  localparam out_t LUSE  = '{rs: 2'd0, rt: 2'd0, pc: 1'b0, ifid: 1'b0, hold: 1'b0, bub: 1'b1, flush: 3'b000};
  localparam out_t HOLD  = '{rs: 2'd0, rt: 2'd0, pc: 1'b0, ifid: 1'b0, hold: 1'b1, bub: 1'b0, flush: 3'b000};
  localparam out_t BR    = '{rs: 2'd0, rt: 2'd0, pc: 1'b1, ifid: 1'b1, hold: 1'b0, bub: 1'b0, flush: 3'b111};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs_addr = 5'd0, id_rt_addr = 5'd0, ex_rs_addr = 5'd0, ex_rt_addr = 5'd0;
  logic [4:0] ex_rd_addr = 5'd0, mem_rd_addr = 5'd0, wb_rd_addr = 5'd0;
  logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_multi_start = 1'b0;
  logic       mem_reg_write = 1'b0, wb_reg_write = 1'b0, branch_taken = 1'b0;
  logic       dbg_step_mode = 1'b0, dbg_step = 1'b0;

  logic [1:0]  fw_rs_sel, fw_rt_sel, w_fw_rs, w_fw_rt;
  logic        pc_enable, ifid_enable, ex_hold, idex_bubble;
  logic        w_pc, w_ifid, w_hold, w_bub;
  logic [2:0]  flush_mask, w_flush;
  logic [15:0] stall_cycles, step_count;
  logic [3:0]  w_stall, w_step;

  int  n_checks = 0;
  int  n_fail = 0;
  int  exp_stall = 0;
  int  exp_step = 0;
  bit  cnt_known = 1'b0;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  hazard_ctrl_unit dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_multi_start(ex_multi_start),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .branch_taken(branch_taken), .dbg_step_mode(dbg_step_mode), .dbg_step(dbg_step),
    .fw_rs_sel(fw_rs_sel), .fw_rt_sel(fw_rt_sel), .pc_enable(pc_enable),
    .ifid_enable(ifid_enable), .ex_hold(ex_hold), .idex_bubble(idex_bubble),
    .flush_mask(flush_mask), .stall_cycles(stall_cycles), .step_count(step_count)
  );

  hazard_ctrl_unit #(.CNT_BITS(4)) dut_w (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rt(id_uses_rt),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_multi_start(ex_multi_start),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .branch_taken(branch_taken), .dbg_step_mode(dbg_step_mode), .dbg_step(dbg_step),
    .fw_rs_sel(w_fw_rs), .fw_rt_sel(w_fw_rt), .pc_enable(w_pc),
    .ifid_enable(w_ifid), .ex_hold(w_hold), .idex_bubble(w_bub),
    .flush_mask(w_flush), .stall_cycles(w_stall), .step_count(w_step)
  );

  function automatic out_t observed();
    return {fw_rs_sel, fw_rt_sel, pc_enable, ifid_enable, ex_hold, idex_bubble, flush_mask};
  endfunction

  function automatic logic [39:0] counters();
    return {stall_cycles, step_count, w_stall, w_step};
  endfunction

  function automatic out_t fw(input logic [1:0] rs, input logic [1:0] rt);
    out_t o;
    o = FREE;
    o.rs = rs;
    o.rt = rt;
    return o;
  endfunction

  // Applies one cycle of stimulus and queues what the DUT must show for it;
  // counters shown in a cycle reflect only the cycles before it.
  task automatic drive(input in_t s, input out_t e);
    sb_t ent;
    @(posedge clk);
    #1;
    reset = s.rst; id_rs_addr = s.id_rs; id_rt_addr = s.id_rt; id_uses_rt = s.id_uses_rt;
    ex_rs_addr = s.ex_rs; ex_rt_addr = s.ex_rt; ex_mem_read = s.ex_mem_read; ex_rd_addr = s.ex_rd;
    ex_multi_start = s.ex_multi_start; mem_reg_write = s.mem_reg_write; mem_rd_addr = s.mem_rd;
    wb_reg_write = s.wb_reg_write; wb_rd_addr = s.wb_rd; branch_taken = s.branch_taken;
    dbg_step_mode = s.dbg_step_mode; dbg_step = s.dbg_step;
    ent.o     = e;
    ent.cnt   = {16'(exp_stall), 16'(exp_step), 4'(exp_stall % 16), 4'(exp_step % 16)};
    ent.valid = cnt_known;
    sb_q.push_back(ent);
    if (s.rst) begin
      exp_stall = 0;
      exp_step  = 0;
      cnt_known = 1'b1;
    end else begin
      if (!e.pc) exp_stall++;
      if (s.dbg_step_mode && s.dbg_step) exp_step++;
    end
  endtask

  task automatic test_reset();
    in_t s[4]; out_t e[4]; sb_t x;
    foreach (s[i]) s[i] = '0;
    s[0].rst = 1'b1;                                  e[0] = RST;
    s[1].rst = 1'b1; s[1].mem_reg_write = 1'b1; s[1].mem_rd = 5'd3; s[1].ex_rs = 5'd3;
    s[1].ex_rt = 5'd3; s[1].branch_taken = 1'b1; s[1].dbg_step_mode = 1'b1; s[1].dbg_step = 1'b1;
                                                      e[1] = RST;
    e[2] = FREE; e[3] = FREE;
    for (int i = 0; i < 4; i++) begin
      drive(s[i], e[i]);
      #3;
      x = sb_q.pop_front();
      n_checks++;
      if (observed() !== x.o) begin
        n_fail++;
        $display("FAIL reset[%0d] outputs got %b want %b", i, observed(), x.o);
      end
      if (x.valid) begin
        n_checks++;
        if (counters() !== x.cnt) begin
          n_fail++;
          $display("FAIL reset[%0d] counters got %h want %h", i, counters(), x.cnt);
        end
      end
    end
  endtask

  task automatic test_forwarding();
    in_t s[5]; out_t e[5]; sb_t x;
    foreach (s[i]) s[i] = '0;
    s[0].mem_reg_write = 1'b1; s[0].wb_reg_write = 1'b1; s[0].mem_rd = 5'd3; s[0].wb_rd = 5'd3;
    s[0].ex_rs = 5'd3;                                e[0] = fw(2'd1, 2'd0);
    s[1] = s[0]; s[1].mem_reg_write = 1'b0;           e[1] = fw(2'd2, 2'd0);
    s[2].mem_reg_write = 1'b1; s[2].wb_reg_write = 1'b1;
                                                      e[2] = fw(2'd0, 2'd0);
    s[3].mem_reg_write = 1'b1; s[3].wb_reg_write = 1'b1; s[3].mem_rd = 5'd3; s[3].wb_rd = 5'd7;
    s[3].ex_rs = 5'd3; s[3].ex_rt = 5'd7;             e[3] = fw(2'd1, 2'd2);
    s[4].mem_reg_write = 1'b1; s[4].wb_reg_write = 1'b1; s[4].mem_rd = 5'd9; s[4].wb_rd = 5'd9;
    s[4].ex_rs = 5'd9; s[4].ex_rt = 5'd9;             e[4] = fw(2'd1, 2'd1);
    for (int i = 0; i < 5; i++) begin
      drive(s[i], e[i]);
      #3;
      x = sb_q.pop_front();
      n_checks++;
      if (observed() !== x.o) begin
        n_fail++;
        $display("FAIL forwarding[%0d] outputs got %b want %b", i, observed(), x.o);
      end
    end
  endtask

  task automatic test_load_use();
    in_t s[6]; out_t e[6]; sb_t x;
    foreach (s[i]) s[i] = '0;
    s[0].ex_mem_read = 1'b1; s[0].ex_rd = 5'd5; s[0].id_rt = 5'd5; s[0].id_uses_rt = 1'b1;
    s[0].id_rs = 5'd1;                                e[0] = LUSE;
                                                      e[1] = FREE;
    s[2] = s[0]; s[2].id_uses_rt = 1'b0;              e[2] = FREE;
    s[3] = s[2]; s[3].id_rs = 5'd5;                   e[3] = LUSE;
    s[4].ex_mem_read = 1'b1;                          e[4] = FREE;
                                                      e[5] = FREE;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      #3;
      x = sb_q.pop_front();
      n_checks++;
      if (observed() !== x.o) begin
        n_fail++;
        $display("FAIL load_use[%0d] outputs got %b want %b", i, observed(), x.o);
      end
      n_checks++;
      if (counters() !== x.cnt) begin
        n_fail++;
        $display("FAIL load_use[%0d] counters got %h want %h", i, counters(), x.cnt);
      end
    end
  endtask

  task automatic test_multi();
    in_t s[6]; out_t e[6]; sb_t x;
    foreach (s[i]) s[i] = '0;
    s[0].ex_multi_start = 1'b1;                       e[0] = HOLD;
    s[1].ex_mem_read = 1'b1; s[1].ex_rd = 5'd5; s[1].id_rs = 5'd5;
                                                      e[1] = HOLD;
    s[2].ex_multi_start = 1'b1;                       e[2] = HOLD;
                                                      e[3] = HOLD;
                                                      e[4] = FREE;
                                                      e[5] = FREE;
    for (int i = 0; i < 6; i++) begin
      drive(s[i], e[i]);
      #3;
      x = sb_q.pop_front();
      n_checks++;
      if (observed() !== x.o) begin
        n_fail++;
        $display("FAIL multi[%0d] outputs got %b want %b", i, observed(), x.o);
      end
      n_checks++;
      if (counters() !== x.cnt) begin
        n_fail++;
        $display("FAIL multi[%0d] counters got %h want %h", i, counters(), x.cnt);
      end
    end
  endtask

  task automatic test_branch();
    in_t s[7]; out_t e[7]; sb_t x;
    foreach (s[i]) s[i] = '0;
    s[0].branch_taken = 1'b1;                         e[0] = BR;
    s[1].branch_taken = 1'b1; s[1].ex_mem_read = 1'b1; s[1].ex_rd = 5'd4; s[1].id_rs = 5'd4;
                                                      e[1] = BR;
    s[2].ex_multi_start = 1'b1;                       e[2] = HOLD;
                                                      e[3] = HOLD;
    s[4].branch_taken = 1'b1;                         e[4] = BR;
                                                      e[5] = FREE;
                                                      e[6] = FREE;
    for (int i = 0; i < 7; i++) begin
      drive(s[i], e[i]);
      #3;
      x = sb_q.pop_front();
      n_checks++;
      if (observed() !== x.o) begin
        n_fail++;
        $display("FAIL branch[%0d] outputs got %b want %b", i, observed(), x.o);
      end
    end
  endtask

  task automatic test_debug();
    in_t s[19]; out_t e[19]; sb_t x;
    foreach (s[i]) begin
      s[i] = '0;
      e[i] = HOLD;
    end
    for (int i = 0; i < 11; i++) s[i].dbg_step_mode = 1'b1;
    s[1].branch_taken = 1'b1;
    s[2].dbg_step = 1'b1;                             e[2] = FREE;
    s[6].dbg_step = 1'b1;                             e[6] = FREE;
    s[10].dbg_step = 1'b1; s[10].branch_taken = 1'b1; e[10] = BR;
    s[11].ex_multi_start = 1'b1;
    for (int i = 12; i < 16; i++) s[i].dbg_step_mode = 1'b1;
    s[15].dbg_step = 1'b1;
                                                      e[18] = FREE;
    for (int i = 0; i < 19; i++) begin
      drive(s[i], e[i]);
      #3;
      x = sb_q.pop_front();
      n_checks++;
      if (observed() !== x.o) begin
        n_fail++;
        $display("FAIL debug[%0d] outputs got %b want %b", i, observed(), x.o);
      end
      n_checks++;
      if (counters() !== x.cnt) begin
        n_fail++;
        $display("FAIL debug[%0d] counters got %h want %h", i, counters(), x.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_multi_wrap();
    in_t s[22]; out_t e[22]; sb_t x;
    foreach (s[i]) begin
      s[i] = '0;
      e[i] = FREE;
    end
    s[0].ex_multi_start = 1'b1;                       e[0] = HOLD;
                                                      e[1] = HOLD;
    s[2].rst = 1'b1;                                  e[2] = RST;
    for (int i = 5; i <= 20; i++) begin
      s[i].dbg_step_mode = 1'b1;
      e[i] = HOLD;
    end
    for (int i = 0; i < 22; i++) begin
      drive(s[i], e[i]);
      #3;
      x = sb_q.pop_front();
      n_checks++;
      if (observed() !== x.o) begin
        n_fail++;
        $display("FAIL reset_wrap[%0d] outputs got %b want %b", i, observed(), x.o);
      end
      n_checks++;
      if (counters() !== x.cnt) begin
        n_fail++;
        $display("FAIL reset_wrap[%0d] counters got %h want %h", i, counters(), x.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_multi();
    test_branch();
    test_debug();
    test_reset_mid_multi_wrap();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left %0d want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
